victim_way_sched: RTL and testbench
===================================

Name: victim_way_sched

Overview:
- Replacement scheduler for the 16-way set's valid-bit state. Serves two miss requesters, e.g. fetch-side and load/store-side refill.
- Arbitrates between the requesters round-robin and picks a victim way for each grant:
  - the lowest-index invalid way if one exists;
  - otherwise a pseudo-random way from an internal LFSR.
- Sequences the refill handshake and owns the 16 valid bits: set on fill completion, cleared on invalidate or flush.

Parameters:
- WAYS, 16, number of ways; must equal 2**WAY_W.
- WAY_W, 4, way index width.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- req0  in  1  refill request, requester 0; held until gnt0.
- req1  in  1  refill request, requester 1; held until gnt1.
- gnt0  out  1  one-cycle grant to requester 0; victim_way valid with it.
- gnt1  out  1  one-cycle grant to requester 1; victim_way valid with it.
- victim_way  out  WAY_W  selected way; held stable until the operation ends.
- victim_was_valid  out  1  1 = victim was valid (eviction needed), 0 = invalid way used.
- fill_done  in  1  owner reports refill complete.
- fill_abort  in  1  owner abandons refill; valid bit untouched.
- inv_en  in  1  invalidate request.
- inv_way  in  WAY_W  way to invalidate.
- flush  in  1  clear all valid bits and abort any operation.
- valid_vec  out  WAYS  current valid bits, registered.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is synchronous, active-low. Mid-operation reset overrides everything.
  - state=IDLE; valid_vec=0; gnt0=gnt1=0; victim_way=0; victim_was_valid=0.
  - Round-robin priority points to requester 0; LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances every cycle out of reset regardless of state.
  - Random candidate = lfsr[WAY_W-1:0].
- States: IDLE, SELECT, WAIT_FILL.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one of req0/req1 high: latch that requester as owner.
  - Both high: the requester holding priority wins.
  - If any request is present, go to SELECT next cycle.
- SELECT (one cycle):
  - Victim = lowest index i with valid_vec[i]==0. If all 16 ways are valid, victim = LFSR candidate, with victim_was_valid=1.
  - Uses valid_vec as it stands in this cycle. An invalidate in the same cycle is not seen until the next cycle.
  - Registers victim_way, victim_was_valid and the owner's gnt. Next state WAIT_FILL.
- Grant timing: request sampled in IDLE at cycle N → gnt high during cycle N+2 only, which is the first WAIT_FILL cycle.
- Withdrawing a request after it has been sampled has no effect; the grant is still issued.
- WAIT_FILL (fill_done/fill_abort accepted in any cycle, including the grant cycle):
  - fill_done: set valid_vec[victim_way]=1, give priority to the non-owner, return to IDLE.
  - fill_abort: return to IDLE without touching valid_vec; priority still moves to the non-owner.
  - fill_done and fill_abort together: fill_done wins.
- Round-robin: requester 1 requesting during requester 0's operation is served next, even if req0 is re-raised. No starvation.
- Invalidate:
  - inv_en clears valid_vec[inv_way] next cycle, in any state.
  - Same cycle and same way as an accepted fill_done: the fill wins and the bit ends at 1.
- Flush:
  - Highest priority after reset; all valid bits go to 0.
  - Any pending gnt is suppressed; state goes to IDLE next cycle.
  - fill_done in the same cycle is ignored.
  - The owner must treat an in-flight refill as aborted.
- After returning to IDLE, at least one IDLE cycle precedes the next SELECT, so back-to-back grants are ≥3 cycles apart.
- Outputs are all registered. gnt0 and gnt1 are never high together.

Test Plan:
- Reset, then req0=1 at cycle 0 → gnt0=1 at cycle 2 only, victim_way=0, victim_was_valid=0. fill_done at cycle 4 → valid_vec=16'h0001 at cycle 5, busy=0.
- valid_vec=16'hFFF7; req1 pulse → victim_way=3, victim_was_valid=0. After fill_done → valid_vec=16'hFFFF.
- All ways valid, LFSR at seed; 8 successive req0/fill_done operations:
  - victim_way equals lfsr[3:0] at each SELECT cycle, matched against the reference model;
  - victim_was_valid=1 every time.
- req0 and req1 both held continuously from reset → grants alternate 0,1,0,1. gnt0 and gnt1 never coincide.
- fill_abort during WAIT_FILL → valid_vec unchanged. inv_en with inv_way=5 and fill_done on victim 5 in the same cycle → valid_vec[5]=1.
- flush asserted on the grant cycle → gnt dropped next cycle, valid_vec=0, state IDLE. reset_n=0 during WAIT_FILL → all outputs return to their reset values next edge.

Source files
------------

// File: rtl/victim_way_sched.sv
// Replacement scheduler for one 16-way set: arbitrates two refill requesters
// round-robin, picks a victim way (lowest invalid, else LFSR), sequences the
// refill handshake and owns the per-way valid bits.
module victim_way_sched #(
    parameter int unsigned WAYS      = 16,
    parameter int unsigned WAY_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_was_valid,
    input  logic             fill_done,
    input  logic             fill_abort,
    input  logic             inv_en,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             flush,
    output logic [WAYS-1:0]  valid_vec,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StWaitFill
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;   // 0 = requester 0 owns the operation
    logic               prio_q, prio_d;     // requester that wins a tie
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               vwv_q, vwv_d;
    logic [WAYS-1:0]    valid_q, valid_d;
    logic [15:0]        lfsr_q, lfsr_d;

    logic               free_found;
    logic [WAY_W-1:0]   free_idx;

    // Lowest-index invalid way; scanning downwards lets the last hit be the lowest.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = WAY_W'(i);
            end
        end
    end

    // Next-state logic: arbitration, victim choice, fill/abort, invalidate, flush.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        victim_d = victim_q;
        vwv_d    = vwv_q;
        valid_d  = valid_q;
        // Galois right-shift form of x^16+x^14+x^13+x^11.
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        // Applied before the fill so a same-way fill_done wins.
        if (inv_en) begin
            valid_d[inv_way] = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    owner_d = (req0 && req1) ? prio_q : req1;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                victim_d = free_found ? free_idx : lfsr_q[WAY_W-1:0];
                vwv_d    = !free_found;
                gnt0_d   = !owner_q;
                gnt1_d   = owner_q;
                state_d  = StWaitFill;
            end
            StWaitFill: begin
                if (fill_done) begin
                    valid_d[victim_q] = 1'b1;
                    prio_d            = !owner_q;
                    state_d           = StIdle;
                end else if (fill_abort) begin
                    prio_d  = !owner_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush cancels everything in flight, including a same-cycle fill_done.
        if (flush) begin
            valid_d  = '0;
            gnt0_d   = 1'b0;
            gnt1_d   = 1'b0;
            victim_d = victim_q;
            vwv_d    = vwv_q;
            prio_d   = prio_q;
            state_d  = StIdle;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            victim_q <= '0;
            vwv_q    <= 1'b0;
            valid_q  <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            victim_q <= victim_d;
            vwv_q    <= vwv_d;
            valid_q  <= valid_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign gnt0             = gnt0_q;
    assign gnt1             = gnt1_q;
    assign victim_way       = victim_q;
    assign victim_was_valid = vwv_q;
    assign valid_vec        = valid_q;
    assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_victim_way_sched.sv
// Self-checking bench for victim_way_sched: a per-cycle vector table for the
// basic handshake, plus directed sequences for fill-all, LFSR victims,
// reset mid-operation and continuous dual requests.
module tb_victim_way_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic [3:0]  victim_way;
    logic        victim_was_valid;
    logic        fill_done, fill_abort;
    logic        inv_en;
    logic [3:0]  inv_way;
    logic        flush;
    logic [15:0] valid_vec;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference LFSR and its value one cycle back (the SELECT cycle at grant time).
    logic [15:0] lfsr_m, lfsr_prev;

    victim_way_sched #(
        .WAYS      (16),
        .WAY_W     (4),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req0             (req0),
        .req1             (req1),
        .gnt0             (gnt0),
        .gnt1             (gnt1),
        .victim_way       (victim_way),
        .victim_was_valid (victim_was_valid),
        .fill_done        (fill_done),
        .fill_abort       (fill_abort),
        .inv_en           (inv_en),
        .inv_way          (inv_way),
        .flush            (flush),
        .valid_vec        (valid_vec),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (!reset_n) lfsr_m <= 16'hACE1;
        else          lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; fill_done = 0; fill_abort = 0;
        inv_en = 0; inv_way = 0; flush = 0;
    endtask

    // Returns at a negedge, with reset just released and outputs at reset values.
    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    // Entered at a negedge in IDLE; raises a request, expects the grant two cycles
    // later on the right line, completes the fill on the grant cycle.
    task automatic do_op(input logic who, output logic [3:0] vw, output logic vv,
                         output logic [15:0] lsel);
        int  k;
        bit  got;
        got  = 0;
        req0 = !who;
        req1 = who;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got = 1;
                break;
            end
        end
        chk("op_latency", 32'(k), 32'd2);
        chk("op_gnt_line", {30'd0, gnt1, gnt0}, who ? 32'd2 : 32'd1);
        vw   = victim_way;
        vv   = victim_was_valid;
        lsel = lfsr_prev;
        req0 = 0;
        req1 = 0;
        fill_done = got;
        @(negedge clk);
        fill_done = 0;
    endtask

    typedef struct {
        logic       r0, r1, fd, fa, ie;
        logic [3:0] iw;
        logic       fl;
        logic       g0, g1;
        logic [3:0] vw;
        logic       vv;
        logic [15:0] val;
        logic       bz;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [3:0]  vw;
        logic        vv;
        logic [15:0] ls;
        int          ngnt;
        int          seq[4];
        bit          both;

        // r0 r1 fd fa ie iw fl | g0 g1 vw vv val bz  (outputs expected during the row's cycle)
        tbl[0]  = '{1,0,0,0,0,4'd0,0, 0,0,4'd0,0,16'h0000,0};
        tbl[1]  = '{0,0,0,0,0,4'd0,0, 0,0,4'd0,0,16'h0000,1}; // request withdrawn after sampling
        tbl[2]  = '{0,0,0,0,0,4'd0,0, 1,0,4'd0,0,16'h0000,1};
        tbl[3]  = '{0,0,0,0,0,4'd0,0, 0,0,4'd0,0,16'h0000,1};
        tbl[4]  = '{0,0,1,0,0,4'd0,0, 0,0,4'd0,0,16'h0000,1};
        tbl[5]  = '{0,1,0,0,0,4'd0,0, 0,0,4'd0,0,16'h0001,0};
        tbl[6]  = '{0,1,0,0,0,4'd0,0, 0,0,4'd0,0,16'h0001,1};
        tbl[7]  = '{0,0,0,1,0,4'd0,0, 0,1,4'd1,0,16'h0001,1}; // abort on grant cycle
        tbl[8]  = '{1,1,0,0,0,4'd0,0, 0,0,4'd1,0,16'h0001,0}; // tie, priority back at 0
        tbl[9]  = '{1,1,0,0,0,4'd0,0, 0,0,4'd1,0,16'h0001,1};
        tbl[10] = '{0,1,1,0,1,4'd0,0, 1,0,4'd1,0,16'h0001,1}; // fill way1, inv way0
        tbl[11] = '{1,1,0,0,0,4'd0,0, 0,0,4'd1,0,16'h0002,0}; // req1 served despite req0
        tbl[12] = '{1,0,0,0,0,4'd0,0, 0,0,4'd1,0,16'h0002,1};
        tbl[13] = '{1,0,1,0,1,4'd0,0, 0,1,4'd0,0,16'h0002,1}; // fill and inv same way
        tbl[14] = '{1,0,0,0,0,4'd0,0, 0,0,4'd0,0,16'h0003,0};
        tbl[15] = '{1,0,0,0,0,4'd0,0, 0,0,4'd0,0,16'h0003,1};
        tbl[16] = '{0,0,1,0,0,4'd0,1, 1,0,4'd2,0,16'h0003,1}; // flush + fill_done on grant
        tbl[17] = '{0,0,0,0,0,4'd0,0, 0,0,4'd2,0,16'h0000,0};
        tbl[18] = '{0,0,0,0,0,4'd0,0, 0,0,4'd2,0,16'h0000,0};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            chk($sformatf("tbl%0d_gnt0", i),   32'(gnt0),             32'(tbl[i].g0));
            chk($sformatf("tbl%0d_gnt1", i),   32'(gnt1),             32'(tbl[i].g1));
            chk($sformatf("tbl%0d_victim", i), 32'(victim_way),       32'(tbl[i].vw));
            chk($sformatf("tbl%0d_vwv", i),    32'(victim_was_valid), 32'(tbl[i].vv));
            chk($sformatf("tbl%0d_valid", i),  32'(valid_vec),        32'(tbl[i].val));
            chk($sformatf("tbl%0d_busy", i),   32'(busy),             32'(tbl[i].bz));
            req0 = tbl[i].r0; req1 = tbl[i].r1; fill_done = tbl[i].fd;
            fill_abort = tbl[i].fa; inv_en = tbl[i].ie; inv_way = tbl[i].iw;
            flush = tbl[i].fl;
            @(negedge clk);
        end
        clear_inputs();

        // Fill every way in order, then punch a hole at way 3 and refill it.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_op(1'(i % 2), vw, vv, ls);
            chk($sformatf("fill%0d_victim", i), 32'(vw), 32'(i));
            chk($sformatf("fill%0d_vwv", i),    32'(vv), 32'd0);
        end
        chk("fill_all_valid", 32'(valid_vec), 32'h0000FFFF);
        inv_en = 1; inv_way = 4'd3;
        @(negedge clk);
        inv_en = 0;
        chk("inv3_valid", 32'(valid_vec), 32'h0000FFF7);
        do_op(1'b1, vw, vv, ls);
        chk("hole_victim", 32'(vw), 32'd3);
        chk("hole_vwv",    32'(vv), 32'd0);
        chk("hole_valid",  32'(valid_vec), 32'h0000FFFF);

        // All ways valid: victims come from the LFSR at the SELECT cycle.
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, vw, vv, ls);
            chk($sformatf("rand%0d_victim", i), 32'(vw), 32'(ls[3:0]));
            chk($sformatf("rand%0d_vwv", i),    32'(vv), 32'd1);
        end
        chk("rand_valid", 32'(valid_vec), 32'h0000FFFF);

        // Reset asserted on the grant cycle of an operation.
        req0 = 1;
        ngnt = 0;
        for (int k = 0; k < 8 && ngnt == 0; k++) begin
            @(negedge clk);
            if (gnt0) ngnt = 1;
        end
        chk("rst_pre_gnt", 32'(ngnt), 32'd1);
        reset_n = 0;
        req0    = 0;
        @(negedge clk);
        chk("rst_gnt0",   32'(gnt0),             32'd0);
        chk("rst_gnt1",   32'(gnt1),             32'd0);
        chk("rst_victim", 32'(victim_way),       32'd0);
        chk("rst_vwv",    32'(victim_was_valid), 32'd0);
        chk("rst_valid",  32'(valid_vec),        32'd0);
        chk("rst_busy",   32'(busy),             32'd0);
        reset_n = 1;

        // Both requesters held from reset: grants must alternate starting at 0.
        do_reset();
        req0 = 1; req1 = 1;
        ngnt = 0;
        both = 0;
        for (int k = 0; k < 40 && ngnt < 4; k++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both = 1;
            if (gnt0 || gnt1) begin
                seq[ngnt] = gnt1 ? 1 : 0;
                ngnt++;
            end
            fill_done = gnt0 | gnt1;
        end
        fill_done = 0; req0 = 0; req1 = 0;
        chk("rr_count", 32'(ngnt), 32'd4);
        chk("rr_exclusive", 32'(both), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < ngnt) chk($sformatf("rr_seq%0d", i), 32'(seq[i]), 32'(i % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

endmodule
